// File: rtl/conv_layer_sched_pkg.sv
// Shared definitions for the conv layer sequencer: FSM state encoding and
// descriptor word field positions {in_ch, out_ch, map_size}.
package conv_layer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int IN_CH_MSB    = 31;
    localparam int IN_CH_LSB    = 24;
    localparam int OUT_CH_MSB   = 23;
    localparam int OUT_CH_LSB   = 16;
    localparam int MAP_SIZE_MSB = 15;
    localparam int MAP_SIZE_LSB = 0;

    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/conv_layer_sched_layer_desc_ram.sv
// Layer descriptor table: 2^AW x 32, one synchronous write port, async read.
// Contents are not reset; the host must write a descriptor before it is run.
module layer_desc_ram #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Host write port
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Async read returns pre-write contents during a same-cycle write
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Layer-level sequencer for the conv MAC array. Walks descriptors
// 0..run_num_layers-1, requesting a weight load then starting the MAC array
// for each layer. Optional macro PERF_CNT_EN adds the perf_cycles port and
// a saturating per-layer RUN cycle counter.
//
// state | meaning
// IDLE  | waiting for run_start
// WLOAD | weight load requested for layer_idx, waiting for wload_ack
// START | one-cycle conv_start pulse to the MAC array
// RUN   | waiting for conv_done from the MAC array
// NEXT  | advance to next layer or finish
// DONE  | one-cycle run_done pulse
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int LAYER_AW = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wen,
    input  logic [LAYER_AW-1:0] cfg_waddr,
    input  logic [31:0]         cfg_wdata,
    input  logic                run_start,
    input  logic [LAYER_AW:0]   run_num_layers,
    input  logic                run_abort,
    output logic                run_busy,
    output logic                run_done,
    output logic [LAYER_AW-1:0] layer_idx,
    output logic                wload_req,
    output logic [LAYER_AW-1:0] wload_layer,
    input  logic                wload_ack,
    output logic                conv_start,
    input  logic                conv_done,
    output logic [7:0]          in_ch,
    output logic [7:0]          out_ch,
    output logic [15:0]         map_size
`ifdef PERF_CNT_EN
    ,output logic [31:0]        perf_cycles
`endif
);

    localparam logic [LAYER_AW:0]   N_ONE   = 1;
    localparam logic [LAYER_AW-1:0] IDX_ONE = 1;

    state_t              state_q, state_d;
    logic [LAYER_AW:0]   n_lyr_q;
    logic                load_n;
    logic [LAYER_AW-1:0] idx_d;
    logic                latch_desc;
    logic [31:0]         rd_data;

    // The read address is the index the FSM is about to enter WLOAD with, so
    // the descriptor is captured on the same edge that enters WLOAD.
    layer_desc_ram #(.AW(LAYER_AW)) u_desc_ram (
        .clk   (clk),
        .wen   (cfg_wen),
        .waddr (cfg_waddr),
        .wdata (cfg_wdata),
        .raddr (idx_d),
        .rdata (rd_data)
    );

    // State, layer counter and latched layer count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            layer_idx <= '0;
            n_lyr_q   <= '0;
        end else begin
            state_q   <= state_d;
            layer_idx <= idx_d;
            if (load_n) begin
                n_lyr_q <= run_num_layers;
            end
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_d    = state_q;
        idx_d      = layer_idx;
        latch_desc = 1'b0;
        load_n     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_start) begin
                    load_n = 1'b1;
                    idx_d  = '0;
                    if (run_num_layers == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_WLOAD;
                        latch_desc = 1'b1;
                    end
                end
            end
            ST_WLOAD: begin
                if (wload_ack) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (conv_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if ({1'b0, layer_idx} == n_lyr_q - N_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d      = layer_idx + IDX_ONE;
                    state_d    = ST_WLOAD;
                    latch_desc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (run_abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            idx_d      = layer_idx;
            latch_desc = 1'b0;
            load_n     = 1'b0;
        end
    end

    // Layer config captured on WLOAD entry; held through abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ch    <= '0;
            out_ch   <= '0;
            map_size <= '0;
        end else if (latch_desc) begin
            in_ch    <= rd_data[IN_CH_MSB:IN_CH_LSB];
            out_ch   <= rd_data[OUT_CH_MSB:OUT_CH_LSB];
            map_size <= rd_data[MAP_SIZE_MSB:MAP_SIZE_LSB];
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        run_busy    = (state_q != ST_IDLE);
        wload_req   = (state_q == ST_WLOAD);
        conv_start  = (state_q == ST_START);
        run_done    = (state_q == ST_DONE);
        wload_layer = layer_idx;
    end

`ifdef PERF_CNT_EN
    logic [31:0] perf_cnt;

    // RUN cycle counter, saturating; result includes the conv_done cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state_q == ST_START) begin
                perf_cnt <= '0;
            end else if (state_q == ST_RUN && perf_cnt != PERF_MAX) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (state_q == ST_RUN && conv_done && !run_abort) begin
                perf_cycles <= (perf_cnt == PERF_MAX) ? PERF_MAX : perf_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: the driver pushes expected
// wload/conv/done events from a descriptor-table model, a monitor pops and
// compares whenever the DUT presents one.
module tb_conv_layer_sched;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wen = 1'b0;
    logic [AW-1:0] cfg_waddr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic          run_start = 1'b0;
    logic [AW:0]   run_num_layers = '0;
    logic          run_abort = 1'b0;
    logic          run_busy, run_done, wload_req, conv_start;
    logic [AW-1:0] layer_idx, wload_layer;
    logic          wload_ack = 1'b0;
    logic          conv_done = 1'b0;
    logic [7:0]    in_ch, out_ch;
    logic [15:0]   map_size;
`ifdef PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    conv_layer_sched #(.LAYER_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_wen        (cfg_wen),
        .cfg_waddr      (cfg_waddr),
        .cfg_wdata      (cfg_wdata),
        .run_start      (run_start),
        .run_num_layers (run_num_layers),
        .run_abort      (run_abort),
        .run_busy       (run_busy),
        .run_done       (run_done),
        .layer_idx      (layer_idx),
        .wload_req      (wload_req),
        .wload_layer    (wload_layer),
        .wload_ack      (wload_ack),
        .conv_start     (conv_start),
        .conv_done      (conv_done),
        .in_ch          (in_ch),
        .out_ch         (out_ch),
        .map_size       (map_size)
`ifdef PERF_CNT_EN
        ,.perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = weight load request, 1 = conv start, 2 = run done
        int layer;
        int ic;
        int oc;
        int ms;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [8];
    int          checks = 0;
    int          passes = 0;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endfunction

    function automatic void push_layer(int k);
        exp_t e;
        e.kind = 0; e.layer = k; e.ic = 0; e.oc = 0; e.ms = 0;
        exp_q.push_back(e);
        e.kind = 1;
        e.ic = int'(model[k][31:24]);
        e.oc = int'(model[k][23:16]);
        e.ms = int'(model[k][15:0]);
        exp_q.push_back(e);
    endfunction

    function automatic void push_done();
        exp_t e;
        e.kind = 2; e.layer = 0; e.ic = 0; e.oc = 0; e.ms = 0;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops one expected event per presented DUT event
    logic wreq_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (wload_req && !wreq_prev) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                        chk("unexpected_wload_req", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wload_layer", wload_layer, e.layer);
                        chk("wload_layer_idx", layer_idx, e.layer);
                    end
                end
                if (conv_start) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                        chk("unexpected_conv_start", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("conv_layer_idx", layer_idx, e.layer);
                        chk("conv_in_ch", in_ch, e.ic);
                        chk("conv_out_ch", out_ch, e.oc);
                        chk("conv_map_size", map_size, e.ms);
                    end
                end
                if (run_done) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
                        chk("unexpected_run_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_while_busy", run_busy, 1);
                    end
                end
            end
            wreq_prev = wload_req;
        end
    end

    task automatic cfg_write(input int idx, input logic [31:0] d);
        @(negedge clk);
        cfg_wen = 1'b1; cfg_waddr = AW'(idx); cfg_wdata = d;
        @(negedge clk);
        cfg_wen = 1'b0;
        model[idx] = d;
    endtask

    // One run. abort_layer/rewrite_layer/rbw_layer of -1 disable that feature;
    // fixed_len of 0 selects a random RUN length.
    task automatic do_run(input int n, input int abort_layer, input bit stray,
                          input int rewrite_layer, input int rewrite_idx,
                          input int rbw_layer, input int fixed_len);
        int  len, hold, waitc;
        bit  got;
        @(negedge clk);
        run_num_layers = (AW+1)'(n);
        run_start = 1'b1;
        if (n == 0) push_done(); else push_layer(0);
        @(negedge clk);
        run_start = 1'b0;
        if (n == 0) begin
            chk("zero_layer_done_latency", run_done, 1);
            chk("zero_layer_no_wload", wload_req, 0);
            @(negedge clk);
            chk("zero_layer_idle", run_busy, 0);
            chk("zero_layer_drained", exp_q.size(), 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (waitc = 0; waitc < 20; waitc++) begin
                if (wload_req) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin chk("wload_req_timeout", 0, 1); return; end
            hold = stray ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            for (int h = 0; h < hold; h++) begin
                conv_done = stray;
                @(negedge clk);
                conv_done = 1'b0;
            end
            chk("still_in_wload", wload_req, 1);
            wload_ack = 1'b1;
            @(negedge clk);
            wload_ack = 1'b0;
            chk("start_after_ack", conv_start, 1);
            chk("wload_req_dropped", wload_req, 0);
            len = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 8));
            for (int j = 1; j <= len; j++) begin
                @(negedge clk);
                wload_ack = 1'b0; run_start = 1'b0; cfg_wen = 1'b0;
                if (stray && j == 1) begin
                    wload_ack = 1'b1;
                    run_start = 1'b1;
                    run_num_layers = (AW+1)'($urandom_range(0, 8));
                end
                if (k == rewrite_layer && j == 1) begin
                    cfg_wen = 1'b1; cfg_waddr = AW'(rewrite_idx);
                    cfg_wdata = ~model[rewrite_idx];
                    model[rewrite_idx] = ~model[rewrite_idx];
                end
                if (k == abort_layer && j == len) begin
                    run_abort = 1'b1;
                    @(negedge clk);
                    run_abort = 1'b0; wload_ack = 1'b0; run_start = 1'b0; cfg_wen = 1'b0;
                    chk("abort_busy_low", run_busy, 0);
                    chk("abort_wload_low", wload_req, 0);
                    repeat (5) @(negedge clk);
                    chk("abort_stays_idle", run_busy, 0);
                    chk("abort_drained", exp_q.size(), 0);
                    return;
                end
                if (j == len) begin
                    conv_done = 1'b1;
                    if (k == n - 1) push_done(); else push_layer(k + 1);
                end
            end
            @(negedge clk);
            conv_done = 1'b0; wload_ack = 1'b0; run_start = 1'b0; cfg_wen = 1'b0;
`ifdef PERF_CNT_EN
            chk("perf_cycles", perf_cycles, len);
`endif
            if (k == rbw_layer && k < n - 1) begin
                // Written on the very edge that enters WLOAD for k+1: old data must win
                cfg_wen = 1'b1; cfg_waddr = AW'(k + 1); cfg_wdata = ~model[k + 1];
                @(negedge clk);
                cfg_wen = 1'b0;
                model[k + 1] = ~model[k + 1];
            end
        end
        got = 1'b0;
        for (waitc = 0; waitc < 10; waitc++) begin
            if (!run_busy) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("run_finished", got, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", run_busy, 0);
        chk("rst_done", run_done, 0);
        chk("rst_wload_req", wload_req, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_layer_idx", layer_idx, 0);
        chk("rst_cfg", {in_ch, out_ch, map_size}, 0);
`ifdef PERF_CNT_EN
        chk("rst_perf", perf_cycles, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Two-layer run with known descriptors
        cfg_write(0, {8'd16, 8'd32, 16'd56});
        cfg_write(1, {8'd32, 8'd64, 16'd28});
        do_run(2, -1, 1'b0, -1, 0, -1, 0);
        chk("two_layer_last_idx", layer_idx, 1);

        // Zero-layer run
        do_run(0, -1, 1'b0, -1, 0, -1, 0);

        for (int i = 0; i < 8; i++) cfg_write(i, $urandom);

        // Stray handshakes and busy run_start are ignored
        do_run(3, -1, 1'b1, -1, 0, -1, 0);

        // Abort in RUN of layer 1, then restart from layer 0
        do_run(3, 1, 1'b0, -1, 0, -1, 0);
        do_run(2, -1, 1'b0, -1, 0, -1, 0);

        // Full table, L5 rewritten while L2 runs
        do_run(8, -1, 1'b0, 2, 5, -1, 0);
        chk("full_run_last_idx", layer_idx, 7);

        // Same-cycle write at WLOAD entry latches old data
        do_run(4, -1, 1'b0, -1, 0, 1, 0);

        // Long single layer (perf count of 100 when enabled)
        do_run(1, -1, 1'b0, -1, 0, -1, 100);

        for (int r = 0; r < 5; r++) begin
            do_run(int'($urandom_range(1, 8)), -1, 1'($urandom_range(0, 1)), -1, 0, -1, 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
